// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: feeds operand beats of a dot-product vector into a pipelined
// DSP MAC slice (A1REG/MREG/PREG) and captures the accumulated P once the
// last product has drained through the slice pipeline.
// Build option: define DSP_MAC_SEQ_OVF_EN to collect CARRYOUT into r_ovf;
// without it r_ovf is tied low and CARRYOUT is ignored.
// LAT is expected to be >= 1 (the slice has at least one register stage).
module dsp_mac_seq #(
  parameter int LAT      = 3,
  parameter int MAXTERMS = 255
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [17:0] s_a,
  input  logic [17:0] s_b,
  input  logic        s_last,
  output logic [17:0] A,
  output logic [17:0] B,
  output logic [7:0]  OPMODE,
  input  logic [47:0] P,
  input  logic        CARRYOUT,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [47:0] r_data,
  output logic        r_trunc,
  output logic        r_ovf
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // X=M, Z=0 starts a fresh sum; X=M, Z=P keeps accumulating (or holds P
  // when the operands are zero).
  localparam logic [7:0] OP_FIRST = 8'h01;
  localparam logic [7:0] OP_ACC   = 8'h09;

  localparam int             DW      = $clog2(LAT + 2) + 1;
  localparam logic [DW-1:0]  CNT_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0]  CNT_ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]  LAT_CNT  = DW'(LAT);
  localparam logic [7:0]     MAX_CNT  = 8'(MAXTERMS);

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [7:0]    term_cnt_r;
  logic [7:0]    term_nxt_s;
  logic [DW-1:0] drain_cnt_r;
  logic          first_d_r;
  logic          accept_s;
  logic          first_s;
  logic          end_s;
  logic          capture_s;
  logic          release_s;
  logic          busy_s;

  // Handshake decode, vector-end detection and next-state selection
  always_comb begin
    accept_s  = s_valid && s_ready;
    first_s   = accept_s && (state_r == ST_IDLE);
    if (first_s) begin
      term_nxt_s = 8'd1;
    end else begin
      term_nxt_s = term_cnt_r + 8'd1;
    end
    end_s     = accept_s && (s_last || (term_nxt_s == MAX_CNT));
    capture_s = (state_r == ST_DRAIN) && (drain_cnt_r == LAT_CNT);
    release_s = (state_r == ST_HOLD) && r_valid && r_ready;
    busy_s    = (state_r == ST_ACC) || (state_r == ST_DRAIN);

    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        // a one-term vector skips ACC so its drain timing matches the rest
        if (end_s) begin
          state_nxt_s = ST_DRAIN;
        end else if (first_s) begin
          state_nxt_s = ST_ACC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (end_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_DRAIN: begin
        if (capture_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (release_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, registered s_ready, term and drain counters
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      s_ready     <= 1'b0;
      term_cnt_r  <= 8'd0;
      drain_cnt_r <= CNT_ZERO;
      first_d_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      s_ready   <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ACC);
      first_d_r <= first_s;
      if (accept_s) begin
        term_cnt_r <= term_nxt_s;
      end else begin
        term_cnt_r <= term_cnt_r;
      end
      if (end_s) begin
        drain_cnt_r <= CNT_ZERO;
      end else if ((state_r == ST_DRAIN) && !capture_s) begin
        drain_cnt_r <= drain_cnt_r + CNT_ONE;
      end else begin
        drain_cnt_r <= drain_cnt_r;
      end
    end
  end

  // Operand and opmode registers toward the slice, result capture and hold
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      A       <= 18'd0;
      B       <= 18'd0;
      OPMODE  <= 8'h00;
      r_data  <= 48'd0;
      r_valid <= 1'b0;
      r_trunc <= 1'b0;
    end else begin
      if (accept_s) begin
        A <= s_a;
        B <= s_b;
      end else begin
        A <= 18'd0;
        B <= 18'd0;
      end
      // opmode trails its operands by one cycle to meet the slice's M stage
      if (first_d_r) begin
        OPMODE <= OP_FIRST;
      end else begin
        OPMODE <= OP_ACC;
      end
      if (capture_s) begin
        r_data  <= P;
        r_valid <= 1'b1;
      end else if (release_s) begin
        r_data  <= r_data;
        r_valid <= 1'b0;
      end else begin
        r_data  <= r_data;
        r_valid <= r_valid;
      end
      if (end_s) begin
        r_trunc <= !s_last;
      end else if (first_s) begin
        r_trunc <= 1'b0;
      end else begin
        r_trunc <= r_trunc;
      end
    end
  end

`ifdef DSP_MAC_SEQ_OVF_EN
  logic [DW-1:0] win_cnt_r;
  logic          ovf_acc_r;
  logic          samp_s;

  // Carry sampling window opens LAT edges after the first beat's edge
  always_comb begin
    samp_s = busy_s && (win_cnt_r == LAT_CNT);
  end

  // Carry accumulation across the window, published to r_ovf on capture
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      win_cnt_r <= CNT_ZERO;
      ovf_acc_r <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (first_s) begin
        win_cnt_r <= CNT_ONE;
      end else if (busy_s && (win_cnt_r != LAT_CNT)) begin
        win_cnt_r <= win_cnt_r + CNT_ONE;
      end else begin
        win_cnt_r <= win_cnt_r;
      end
      if (first_s) begin
        ovf_acc_r <= 1'b0;
      end else if (samp_s) begin
        ovf_acc_r <= ovf_acc_r | CARRYOUT;
      end else begin
        ovf_acc_r <= ovf_acc_r;
      end
      // the capture edge always lies inside the window, so include it here
      if (capture_s) begin
        r_ovf <= ovf_acc_r | CARRYOUT;
      end else if (first_s) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end
`else
  logic unused_carry;
  assign unused_carry = CARRYOUT;
  assign r_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Self-checking bench for dsp_mac_seq with a behavioural DSP slice model
// (A1REG, MREG+OPMODEREG, PREG) and a dot-product reference computed from
// plain arithmetic over the driven beats.
`timescale 1ns/1ps
module tb_dsp_mac_seq;
  localparam int LAT  = 3;
  localparam int MAXT = 4;
`ifdef DSP_MAC_SEQ_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST_N;
  logic        s_valid;
  logic        s_ready;
  logic [17:0] s_a;
  logic [17:0] s_b;
  logic        s_last;
  logic [17:0] A;
  logic [17:0] B;
  logic [7:0]  OPMODE;
  logic [47:0] P;
  logic        CARRYOUT;
  logic        r_valid;
  logic        r_ready;
  logic [47:0] r_data;
  logic        r_trunc;
  logic        r_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dsp_mac_seq #(.LAT(LAT), .MAXTERMS(MAXT)) dut (
    .clk(clk), .RST_N(RST_N), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_last(s_last), .A(A), .B(B), .OPMODE(OPMODE),
    .P(P), .CARRYOUT(CARRYOUT), .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .r_trunc(r_trunc), .r_ovf(r_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural DSP slice: A/B reg, then M reg with opmode reg, then P reg
  logic [17:0] a1, b1;
  logic [47:0] m;
  logic [7:0]  op_q;
  always @(posedge clk) begin
    a1   <= A;
    b1   <= B;
    m    <= 48'(a1) * 48'(b1);
    op_q <= OPMODE;
    case (op_q)
      8'h01:   P <= m;
      8'h09:   P <= P + m;
      default: P <= 48'd0;
    endcase
  end

  task automatic idle_inputs();
    s_valid = 1'b0; s_a = 18'd0; s_b = 18'd0; s_last = 1'b0;
  endtask

  // present a beat, wait for s_ready, return the accepting edge number
  task automatic put_beat(input logic [17:0] a, input logic [17:0] b, input logic last,
                          output int edge_no, output bit ok);
    int n;
    n = 0;
    s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
    while (s_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    ok = (s_ready === 1'b1);
    @(posedge clk); #1;
    edge_no = cyc;
  endtask

  task automatic wait_result(output int edge_no, output bit ok);
    int n;
    n = 0;
    while (r_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    ok = (r_valid === 1'b1);
    edge_no = cyc;
  endtask

  task automatic pop_result();
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; s_valid = 1'b1; s_a = 18'd5; s_b = 18'd7; s_last = 1'b0;
    r_ready = 1'b0; CARRYOUT = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (s_ready !== 1'b0 || A !== 18'd0 || B !== 18'd0 || OPMODE !== 8'h00 ||
          r_valid !== 1'b0 || r_data !== 48'd0 || r_trunc !== 1'b0 || r_ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: s_ready=%b A=%0d B=%0d OPMODE=%h r_valid=%b r_data=%0d r_trunc=%b r_ovf=%b, required all zero",
                 s_ready, A, B, OPMODE, r_valid, r_data, r_trunc, r_ovf);
      end
    end
    idle_inputs();
    RST_N = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1 || OPMODE !== 8'h09 || A !== 18'd0) begin
      errors++;
      $display("FAIL reset_release: s_ready=%b OPMODE=%h A=%0d, required 1 09 0", s_ready, OPMODE, A);
    end
  endtask

  task automatic test_single_beat();
    int k, e; bit ok;
    put_beat(18'd6, 18'd14, 1'b1, k, ok);
    idle_inputs();
    checks++;
    if (!ok || A !== 18'd6 || B !== 18'd14) begin
      errors++; $display("FAIL single_operands: ok=%b A=%0d B=%0d, required 6 14", ok, A, B);
    end
    @(posedge clk); #1;
    checks++;
    if (OPMODE !== 8'h01 || A !== 18'd0 || B !== 18'd0) begin
      errors++; $display("FAIL single_opmode: OPMODE=%h A=%0d B=%0d, required 01 0 0", OPMODE, A, B);
    end
    CARRYOUT = 1'b1;            // sampled at accept+2, just before the window
    @(posedge clk); #1;
    CARRYOUT = 1'b0;
    wait_result(e, ok);
    checks++;
    if (!ok || e - k != LAT + 1) begin
      errors++; $display("FAIL single_latency: ok=%b edges=%0d, required %0d", ok, e - k, LAT + 1);
    end
    checks++;
    if (r_data !== 48'd84 || r_trunc !== 1'b0 || r_ovf !== 1'b0) begin
      errors++; $display("FAIL single_result: r_data=%0d r_trunc=%b r_ovf=%b, required 84 0 0", r_data, r_trunc, r_ovf);
    end
    pop_result();
    checks++;
    if (r_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL single_pop: r_valid=%b s_ready=%b, required 0 1", r_valid, s_ready);
    end
  endtask

  task automatic test_back_to_back();
    int k0, k1, k2, e; bit ok0, ok1, ok2, ok;
    logic [47:0] exp_sum;
    exp_sum = 48'd2 * 48'd3 + 48'd4 * 48'd5 + 48'd6 * 48'd7;
    put_beat(18'd2, 18'd3, 1'b0, k0, ok0);
    put_beat(18'd4, 18'd5, 1'b0, k1, ok1);
    checks++;
    if (A !== 18'd4 || B !== 18'd5 || OPMODE !== 8'h01 || k1 != k0 + 1) begin
      errors++; $display("FAIL b2b_beat2: A=%0d B=%0d OPMODE=%h gap=%0d, required 4 5 01 1", A, B, OPMODE, k1 - k0);
    end
    put_beat(18'd6, 18'd7, 1'b1, k2, ok2);
    idle_inputs();
    checks++;
    if (A !== 18'd6 || OPMODE !== 8'h09 || k2 != k1 + 1) begin
      errors++; $display("FAIL b2b_beat3: A=%0d OPMODE=%h gap=%0d, required 6 09 1", A, OPMODE, k2 - k1);
    end
    @(posedge clk); #1;
    checks++;
    if (OPMODE !== 8'h09 || A !== 18'd0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: OPMODE=%h A=%0d s_ready=%b, required 09 0 0", OPMODE, A, s_ready);
    end
    wait_result(e, ok);
    checks++;
    if (!ok0 || !ok1 || !ok2 || !ok || e - k2 != LAT + 1 || r_data !== exp_sum || r_trunc !== 1'b0) begin
      errors++; $display("FAIL b2b_result: edges=%0d r_data=%0d r_trunc=%b, required %0d %0d 0",
                         e - k2, r_data, r_trunc, LAT + 1, exp_sum);
    end
    pop_result();
  endtask

  task automatic test_bubbles();
    int k0, k1, k2, e; bit ok0, ok1, ok2, ok;
    logic [47:0] exp_sum;
    exp_sum = 48'd2 * 48'd3 + 48'd4 * 48'd5 + 48'd6 * 48'd7;
    put_beat(18'd2, 18'd3, 1'b0, k0, ok0);
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (A !== 18'd0 || B !== 18'd0 || s_ready !== 1'b1) begin
        errors++; $display("FAIL bubble_zero: A=%0d B=%0d s_ready=%b, required 0 0 1", A, B, s_ready);
      end
    end
    put_beat(18'd4, 18'd5, 1'b0, k1, ok1);
    checks++;
    if (A !== 18'd4 || OPMODE !== 8'h09) begin
      errors++; $display("FAIL bubble_beat2: A=%0d OPMODE=%h, required 4 09", A, OPMODE);
    end
    put_beat(18'd6, 18'd7, 1'b1, k2, ok2);
    idle_inputs();
    repeat (LAT) begin @(posedge clk); #1; end
    checks++;
    if (r_valid !== 1'b0) begin
      errors++; $display("FAIL bubble_early: r_valid=%b one edge before capture, required 0", r_valid);
    end
    CARRYOUT = 1'b1;            // sampled on the capture edge itself
    @(posedge clk); #1;
    CARRYOUT = 1'b0;
    wait_result(e, ok);
    checks++;
    if (!ok0 || !ok1 || !ok2 || !ok || e - k2 != LAT + 1 || r_data !== exp_sum || r_ovf !== OVF_ON) begin
      errors++; $display("FAIL bubble_result: edges=%0d r_data=%0d r_ovf=%b, required %0d %0d %b",
                         e - k2, r_data, r_ovf, LAT + 1, exp_sum, OVF_ON);
    end
    pop_result();
  endtask

  task automatic test_hold();
    int k, e; bit ok;
    put_beat(18'd9, 18'd10, 1'b1, k, ok);
    s_a = 18'd3; s_b = 18'd3; s_last = 1'b1;     // next beat waits during hold
    wait_result(e, ok);
    CARRYOUT = 1'b1;                              // outside any window
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (r_valid !== 1'b1 || r_data !== 48'd90 || s_ready !== 1'b0 || r_trunc !== 1'b0 || r_ovf !== 1'b0 || A !== 18'd0) begin
        errors++; $display("FAIL hold_stable: r_valid=%b r_data=%0d s_ready=%b r_trunc=%b r_ovf=%b A=%0d, required 1 90 0 0 0 0",
                           r_valid, r_data, s_ready, r_trunc, r_ovf, A);
      end
    end
    CARRYOUT = 1'b0;
    idle_inputs();
    pop_result();
    checks++;
    if (r_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: r_valid=%b s_ready=%b, required 0 1", r_valid, s_ready);
    end
  endtask

  task automatic test_trunc();
    int k[6]; int e; bit ok, allok;
    allok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put_beat(18'd1, 18'd1, 1'b0, k[i], ok);
      allok = allok & ok;
    end
    CARRYOUT = 1'b1;            // sampled at first+4, inside the window
    @(posedge clk); #1;
    CARRYOUT = 1'b0;
    checks++;
    if (s_ready !== 1'b0 || !allok || k[3] != k[0] + 3) begin
      errors++; $display("FAIL trunc_stop: s_ready=%b span=%0d, required 0 3", s_ready, k[3] - k[0]);
    end
    wait_result(e, ok);
    checks++;
    if (!ok || e - k[3] != LAT + 1 || r_data !== 48'd4 || r_trunc !== 1'b1 || r_ovf !== OVF_ON) begin
      errors++; $display("FAIL trunc_result: edges=%0d r_data=%0d r_trunc=%b r_ovf=%b, required %0d 4 1 %b",
                         e - k[3], r_data, r_trunc, r_ovf, LAT + 1, OVF_ON);
    end
    pop_result();
    checks++;
    if (r_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL trunc_pop: r_valid=%b s_ready=%b, required 0 1", r_valid, s_ready);
    end
    put_beat(18'd1, 18'd1, 1'b0, k[4], ok);
    put_beat(18'd1, 18'd1, 1'b0, k[5], ok);
    checks++;
    if (OPMODE !== 8'h01 || A !== 18'd1 || k[5] != k[4] + 1 || r_trunc !== 1'b0) begin
      errors++; $display("FAIL trunc_newvec: OPMODE=%h A=%0d gap=%0d r_trunc=%b, required 01 1 1 0",
                         OPMODE, A, k[5] - k[4], r_trunc);
    end
    // abort the open vector with reset: no result may appear
    idle_inputs();
    RST_N = 1'b0;
    @(posedge clk); #1;
    RST_N = 1'b1;
    checks++;
    if (s_ready !== 1'b0 || A !== 18'd0 || OPMODE !== 8'h00 || r_trunc !== 1'b0) begin
      errors++; $display("FAIL abort_reset: s_ready=%b A=%0d OPMODE=%h r_trunc=%b, required 0 0 00 0", s_ready, A, OPMODE, r_trunc);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (r_valid !== 1'b0 || s_ready !== 1'b1) begin
        errors++; $display("FAIL abort_quiet: r_valid=%b s_ready=%b, required 0 1", r_valid, s_ready);
      end
    end
  endtask

  task automatic test_random();
    int kk, e, cnt, len, nb, nh; bit ok, last, need_end;
    logic [17:0] a, b;
    logic [47:0] sum;
    cnt = 0; sum = 48'd0;
    for (int v = 0; v < 15; v++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        a = 18'($urandom); b = 18'($urandom);
        last = (i == len - 1);
        put_beat(a, b, last, kk, ok);
        sum = sum + 48'(a) * 48'(b);
        cnt++;
        checks++;
        if (!ok || A !== a || B !== b) begin
          errors++; $display("FAIL rand_operand: ok=%b A=%0d B=%0d, required %0d %0d", ok, A, B, a, b);
        end
        need_end = last || (cnt == MAXT);
        idle_inputs();
        if (need_end) begin
          wait_result(e, ok);
          checks++;
          if (!ok || e - kk != LAT + 1 || r_data !== sum || r_trunc !== !last || r_ovf !== 1'b0) begin
            errors++; $display("FAIL rand_result: vec=%0d edges=%0d r_data=%0d r_trunc=%b r_ovf=%b, required %0d %0d %b 0",
                               v, e - kk, r_data, r_trunc, r_ovf, LAT + 1, sum, !last);
          end
          nh = $urandom_range(0, 3);
          repeat (nh) begin @(posedge clk); #1; end
          pop_result();
          cnt = 0; sum = 48'd0;
        end else begin
          nb = $urandom_range(0, 2);
          repeat (nb) begin
            @(posedge clk); #1;
            checks++;
            if (A !== 18'd0 || B !== 18'd0) begin
              errors++; $display("FAIL rand_bubble: A=%0d B=%0d, required 0 0", A, B);
            end
          end
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    RST_N = 1'b0; r_ready = 1'b0; CARRYOUT = 1'b0;
    #1;
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_bubbles();
    test_hold();
    test_trunc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
